// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared types for the pipeline hazard controller.
//   hz_state_e  : controller modes (RUN, DMEM_WAIT, MD_WAIT)
//   fwd_sel_e   : Execute operand source (register file, Writeback, Memory)
//   reg_match() : true when a non-zero destination register feeds a source
// ---------------------------------------------------------------------------
package pipeline_pkg;

  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned STALL_CNT_W = 32;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    MD_WAIT   = 2'd2
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  // x0 is hard-wired to zero, so a write to it never creates a dependency.
  function automatic logic reg_match(input logic [REG_ADDR_W-1:0] rd,
                                     input logic [REG_ADDR_W-1:0] rs);
    return (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard controller.
//   master : pipeline side, drives register ids / events, receives controls
//   slave  : hazard controller side
// Inputs to the controller : rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
//                            ld_E, regwrite_M, regwrite_W, pcsrc_E,
//                            md_start_E, md_done, dmem_req_M, dmem_ack
// Outputs of the controller: stall_F/D/E/M, flush_D/E/W, fwdA_E, fwdB_E,
//                            stall_cycles
// ---------------------------------------------------------------------------
interface hazard_ctrl_if;
  import pipeline_pkg::*;

  logic [REG_ADDR_W-1:0]  rs1_D, rs2_D;
  logic [REG_ADDR_W-1:0]  rs1_E, rs2_E, rd_E;
  logic [REG_ADDR_W-1:0]  rd_M, rd_W;
  logic                   ld_E;
  logic                   regwrite_M, regwrite_W;
  logic                   pcsrc_E;
  logic                   md_start_E, md_done;
  logic                   dmem_req_M, dmem_ack;

  logic                   stall_F, stall_D, stall_E, stall_M;
  logic                   flush_D, flush_E, flush_W;
  logic [1:0]             fwdA_E, fwdB_E;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport master (
    output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
           ld_E, regwrite_M, regwrite_W, pcsrc_E,
           md_start_E, md_done, dmem_req_M, dmem_ack,
    input  stall_F, stall_D, stall_E, stall_M,
           flush_D, flush_E, flush_W, fwdA_E, fwdB_E, stall_cycles
  );

  modport slave (
    input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
           ld_E, regwrite_M, regwrite_W, pcsrc_E,
           md_start_E, md_done, dmem_req_M, dmem_ack,
    output stall_F, stall_D, stall_E, stall_M,
           flush_D, flush_E, flush_W, fwdA_E, fwdB_E, stall_cycles
  );

endinterface

// File: rtl/forward_unit.sv
// ---------------------------------------------------------------------------
// forward_unit
// Chooses the source of one Execute operand. Memory is the younger producer,
// so it takes priority over Writeback.
//   i_rs                       : source register read in Execute
//   i_rd_M / i_regwrite_M      : Memory-stage destination and write enable
//   i_rd_W / i_regwrite_W      : Writeback-stage destination and write enable
//   o_fwd                      : FWD_M, FWD_W or FWD_RF
// ---------------------------------------------------------------------------
module forward_unit
  import pipeline_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [REG_ADDR_W-1:0] i_rd_M,
  input  logic                  i_regwrite_M,
  input  logic [REG_ADDR_W-1:0] i_rd_W,
  input  logic                  i_regwrite_W,
  output fwd_sel_e              o_fwd
);

  always_comb begin
    o_fwd = FWD_RF;
    if (i_regwrite_M && reg_match(i_rd_M, i_rs)) begin
      o_fwd = FWD_M;
    end else if (i_regwrite_W && reg_match(i_rd_W, i_rs)) begin
      o_fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller: operand forwarding, load-use stalls, branch
// flushes, and freezing the pipe while a data-memory access or a multi-cycle
// mul/div is outstanding. Also counts cycles spent with the fetch stalled.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   io_hz  : hazard_ctrl_if.slave bundle (see hazard_ctrl_if for signals)
// ---------------------------------------------------------------------------
module hazard_ctrl
  import pipeline_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  io_hz
);

  hz_state_e              r_state, w_state_next;
  logic                   r_md_pending, w_md_pending_next;
  logic [STALL_CNT_W-1:0] r_stall_cycles;

  logic     w_load_use;
  logic     w_stall_F, w_stall_D, w_stall_E, w_stall_M;
  logic     w_flush_D, w_flush_E, w_flush_W;
  fwd_sel_e w_fwdA, w_fwdB;

  forward_unit u_fwd_a (
    .i_rs         (io_hz.rs1_E),
    .i_rd_M       (io_hz.rd_M),
    .i_regwrite_M (io_hz.regwrite_M),
    .i_rd_W       (io_hz.rd_W),
    .i_regwrite_W (io_hz.regwrite_W),
    .o_fwd        (w_fwdA)
  );

  forward_unit u_fwd_b (
    .i_rs         (io_hz.rs2_E),
    .i_rd_M       (io_hz.rd_M),
    .i_regwrite_M (io_hz.regwrite_M),
    .i_rd_W       (io_hz.rd_W),
    .i_regwrite_W (io_hz.regwrite_W),
    .o_fwd        (w_fwdB)
  );

  assign w_load_use = io_hz.ld_E &&
                      (reg_match(io_hz.rd_E, io_hz.rs1_D) ||
                       reg_match(io_hz.rd_E, io_hz.rs2_D));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_md_pending <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_md_pending <= w_md_pending_next;
    end
  end

  // A memory wait has priority over a mul/div wait; a mul/div issued alongside
  // an unacknowledged access is remembered in md_pending and served once the
  // access completes, unless the mul/div already finished in the meantime.
  always_comb begin
    w_state_next      = r_state;
    w_md_pending_next = r_md_pending;
    w_stall_F         = 1'b0;
    w_stall_D         = 1'b0;
    w_stall_E         = 1'b0;
    w_stall_M         = 1'b0;
    w_flush_D         = 1'b0;
    w_flush_E         = 1'b0;
    w_flush_W         = 1'b0;
    unique case (r_state)
      RUN: begin
        if (io_hz.pcsrc_E) begin
          w_flush_D = 1'b1;
          w_flush_E = 1'b1;
        end else if (w_load_use) begin
          w_stall_F = 1'b1;
          w_stall_D = 1'b1;
          w_flush_E = 1'b1;
        end
        if (io_hz.dmem_req_M && !io_hz.dmem_ack) begin
          w_state_next      = DMEM_WAIT;
          w_md_pending_next = io_hz.md_start_E;
        end else if (io_hz.md_start_E) begin
          w_state_next = MD_WAIT;
        end
      end
      DMEM_WAIT: begin
        w_stall_F = 1'b1;
        w_stall_D = 1'b1;
        w_stall_E = 1'b1;
        w_stall_M = 1'b1;
        w_flush_W = 1'b1;
        if (io_hz.md_done) begin
          w_md_pending_next = 1'b0;
        end
        if (io_hz.dmem_ack) begin
          w_state_next      = (r_md_pending && !io_hz.md_done) ? MD_WAIT : RUN;
          w_md_pending_next = 1'b0;
        end
      end
      MD_WAIT: begin
        // Memory keeps draining; the stall drops in the very cycle md_done shows.
        if (io_hz.md_done) begin
          w_state_next = RUN;
        end else begin
          w_stall_F = 1'b1;
          w_stall_D = 1'b1;
          w_stall_E = 1'b1;
        end
      end
      default: begin
        w_state_next      = RUN;
        w_md_pending_next = 1'b0;
      end
    endcase
  end

  // Controls are forced low for the whole time reset is held, not just after
  // the next edge, so a frozen pipe is released the moment reset asserts.
  assign io_hz.stall_F = rst_n & w_stall_F;
  assign io_hz.stall_D = rst_n & w_stall_D;
  assign io_hz.stall_E = rst_n & w_stall_E;
  assign io_hz.stall_M = rst_n & w_stall_M;
  assign io_hz.flush_D = rst_n & w_flush_D;
  assign io_hz.flush_E = rst_n & w_flush_E;
  assign io_hz.flush_W = rst_n & w_flush_W;
  assign io_hz.fwdA_E  = w_fwdA;
  assign io_hz.fwdB_E  = w_fwdB;

  // Saturating counter of fetch-stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (io_hz.stall_F && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign io_hz.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized
// run compared against a behavioural model of the controller's rules.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic clk;
  logic rst_n;

  hazard_ctrl_if hz();

  hazard_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_hz (hz)
  );

  int checkCount;
  int errorCount;

  // Behavioural model: which wait the pipe is frozen in and whether a mul/div
  // is queued behind a memory access.
  bit          mDmem;
  bit          mMd;
  bit          mPending;
  logic [31:0] mCount;

  logic [6:0]  eCtl;
  logic [1:0]  eFwdA;
  logic [1:0]  eFwdB;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control outputs packed as {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W}.
  function automatic logic [6:0] ctlVec();
    return {hz.stall_F, hz.stall_D, hz.stall_E, hz.stall_M,
            hz.flush_D, hz.flush_E, hz.flush_W};
  endfunction

  function automatic logic [1:0] refFwd(input logic [4:0] rs);
    if (hz.regwrite_M && hz.rd_M != 5'd0 && hz.rd_M == rs) return 2'b10;
    if (hz.regwrite_W && hz.rd_W != 5'd0 && hz.rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic modelReset();
    mDmem    = 1'b0;
    mMd      = 1'b0;
    mPending = 1'b0;
    mCount   = 32'd0;
  endtask

  task automatic modelOutputs();
    bit loadUse;
    loadUse = hz.ld_E && hz.rd_E != 5'd0 && (hz.rd_E == hz.rs1_D || hz.rd_E == hz.rs2_D);
    eFwdA = refFwd(hz.rs1_E);
    eFwdB = refFwd(hz.rs2_E);
    if (!rst_n)     eCtl = 7'b0000000;
    else if (mDmem) eCtl = 7'b1111001;
    else if (mMd)   eCtl = hz.md_done ? 7'b0000000 : 7'b1110000;
    else if (hz.pcsrc_E) eCtl = 7'b0000110;
    else if (loadUse)    eCtl = 7'b1100010;
    else                 eCtl = 7'b0000000;
  endtask

  task automatic modelAdvance();
    if (eCtl[6] && mCount != 32'hFFFF_FFFF) mCount = mCount + 32'd1;
    if (mDmem) begin
      if (hz.md_done) mPending = 1'b0;
      if (hz.dmem_ack) begin
        mDmem    = 1'b0;
        mMd      = mPending;
        mPending = 1'b0;
      end
    end else if (mMd) begin
      if (hz.md_done) mMd = 1'b0;
    end else if (hz.dmem_req_M && !hz.dmem_ack) begin
      mDmem    = 1'b1;
      mPending = hz.md_start_E;
    end else if (hz.md_start_E) begin
      mMd = 1'b1;
    end
  endtask

  task automatic clearInputs();
    hz.rs1_D = '0; hz.rs2_D = '0; hz.rs1_E = '0; hz.rs2_E = '0;
    hz.rd_E = '0; hz.rd_M = '0; hz.rd_W = '0;
    hz.ld_E = 1'b0; hz.regwrite_M = 1'b0; hz.regwrite_W = 1'b0;
    hz.pcsrc_E = 1'b0; hz.md_start_E = 1'b0; hz.md_done = 1'b0;
    hz.dmem_req_M = 1'b0; hz.dmem_ack = 1'b0;
  endtask

  task automatic applyStimulus();
    hz.rs1_D = 5'($urandom_range(0, 3));
    hz.rs2_D = 5'($urandom_range(0, 3));
    hz.rs1_E = 5'($urandom_range(0, 3));
    hz.rs2_E = 5'($urandom_range(0, 3));
    hz.rd_E  = 5'($urandom_range(0, 3));
    hz.rd_M  = 5'($urandom_range(0, 3));
    hz.rd_W  = 5'($urandom_range(0, 3));
    hz.ld_E       = ($urandom_range(0, 2) == 0);
    hz.regwrite_M = ($urandom_range(0, 1) == 0);
    hz.regwrite_W = ($urandom_range(0, 1) == 0);
    hz.pcsrc_E    = ($urandom_range(0, 5) == 0);
    hz.md_start_E = ($urandom_range(0, 7) == 0);
    hz.md_done    = ($urandom_range(0, 3) == 0);
    hz.dmem_req_M = ($urandom_range(0, 3) == 0);
    hz.dmem_ack   = ($urandom_range(0, 2) == 0);
    rst_n         = ($urandom_range(0, 49) != 0);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    clearInputs();
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reset must force every control low regardless of hazardous inputs.
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    hz.ld_E = 1'b1; hz.rd_E = 5'd7; hz.rs1_D = 5'd7; hz.pcsrc_E = 1'b1;
    hz.dmem_req_M = 1'b1; hz.md_start_E = 1'b1;
    #1;
    checkCount++;
    if (ctlVec() !== 7'b0) begin errorCount++; $display("[TB] FAIL reset_ctl got %b want %b", ctlVec(), 7'b0); end
    checkCount++;
    if (hz.stall_cycles !== 32'd0) begin errorCount++; $display("[TB] FAIL reset_count got %0d want 0", hz.stall_cycles); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checkCount++;
      if (ctlVec() !== 7'b0) begin errorCount++; $display("[TB] FAIL reset_hold_ctl cycle %0d got %b want %b", i, ctlVec(), 7'b0); end
    end
    @(negedge clk);
    clearInputs();
    rst_n = 1'b1;
    @(negedge clk); #1;
    checkCount++;
    if (ctlVec() !== 7'b0) begin errorCount++; $display("[TB] FAIL reset_release_ctl got %b want %b", ctlVec(), 7'b0); end
    checkCount++;
    if (hz.stall_cycles !== 32'd0) begin errorCount++; $display("[TB] FAIL reset_release_count got %0d want 0", hz.stall_cycles); end
  endtask

  task automatic test_forwarding();
    resetDut();
    @(negedge clk);
    hz.rd_M = 5'd5; hz.regwrite_M = 1'b1; hz.rd_W = 5'd5; hz.regwrite_W = 1'b1;
    hz.rs1_E = 5'd5; hz.rs2_E = 5'd5;
    #1;
    checkCount++;
    if (hz.fwdA_E !== 2'b10) begin errorCount++; $display("[TB] FAIL fwd_mem_wins got %b want 10", hz.fwdA_E); end
    checkCount++;
    if (hz.fwdB_E !== 2'b10) begin errorCount++; $display("[TB] FAIL fwdB_mem_wins got %b want 10", hz.fwdB_E); end
    hz.rd_M = 5'd0;
    #1;
    checkCount++;
    if (hz.fwdA_E !== 2'b01) begin errorCount++; $display("[TB] FAIL fwd_rdM_zero got %b want 01", hz.fwdA_E); end
    hz.regwrite_W = 1'b0;
    #1;
    checkCount++;
    if (hz.fwdA_E !== 2'b00) begin errorCount++; $display("[TB] FAIL fwd_no_write got %b want 00", hz.fwdA_E); end
    hz.regwrite_W = 1'b1; hz.rd_W = 5'd0; hz.rs1_E = 5'd0;
    #1;
    checkCount++;
    if (hz.fwdA_E !== 2'b00) begin errorCount++; $display("[TB] FAIL fwd_x0 got %b want 00", hz.fwdA_E); end
    for (int i = 0; i < 40; i++) begin
      applyStimulus();
      rst_n = 1'b1;
      hz.md_start_E = 1'b0; hz.dmem_req_M = 1'b0;
      #1;
      checkCount++;
      if ({hz.fwdA_E, hz.fwdB_E} !== {refFwd(hz.rs1_E), refFwd(hz.rs2_E)})
        begin errorCount++; $display("[TB] FAIL fwd_random %0d got %b want %b", i, {hz.fwdA_E, hz.fwdB_E}, {refFwd(hz.rs1_E), refFwd(hz.rs2_E)}); end
    end
    clearInputs();
  endtask

  task automatic test_load_use();
    resetDut();
    @(negedge clk);
    hz.ld_E = 1'b1; hz.rd_E = 5'd7; hz.rs1_D = 5'd3; hz.rs2_D = 5'd7;
    #1;
    checkCount++;
    if (ctlVec() !== 7'b1100010) begin errorCount++; $display("[TB] FAIL loaduse_ctl got %b want %b", ctlVec(), 7'b1100010); end
    @(negedge clk);
    clearInputs();
    #1;
    checkCount++;
    if (ctlVec() !== 7'b0) begin errorCount++; $display("[TB] FAIL loaduse_one_cycle got %b want %b", ctlVec(), 7'b0); end
    checkCount++;
    if (hz.stall_cycles !== 32'd1) begin errorCount++; $display("[TB] FAIL loaduse_count got %0d want 1", hz.stall_cycles); end
  endtask

  task automatic test_branch_override();
    resetDut();
    @(negedge clk);
    hz.ld_E = 1'b1; hz.rd_E = 5'd7; hz.rs2_D = 5'd7; hz.pcsrc_E = 1'b1;
    #1;
    checkCount++;
    if (ctlVec() !== 7'b0000110) begin errorCount++; $display("[TB] FAIL branch_override got %b want %b", ctlVec(), 7'b0000110); end
    @(negedge clk);
    clearInputs();
    #1;
    checkCount++;
    if (hz.stall_cycles !== 32'd0) begin errorCount++; $display("[TB] FAIL branch_count got %0d want 0", hz.stall_cycles); end
  endtask

  task automatic test_dmem_wait();
    resetDut();
    @(negedge clk);
    hz.dmem_req_M = 1'b1;
    #1;
    checkCount++;
    if (ctlVec() !== 7'b0) begin errorCount++; $display("[TB] FAIL dmem_req_cycle got %b want %b", ctlVec(), 7'b0); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      hz.dmem_ack = (k == 3);
      #1;
      checkCount++;
      if (ctlVec() !== 7'b1111001) begin errorCount++; $display("[TB] FAIL dmem_wait_%0d got %b want %b", k, ctlVec(), 7'b1111001); end
    end
    @(negedge clk);
    hz.dmem_req_M = 1'b0; hz.dmem_ack = 1'b0;
    #1;
    checkCount++;
    if (ctlVec() !== 7'b0) begin errorCount++; $display("[TB] FAIL dmem_back_run got %b want %b", ctlVec(), 7'b0); end
    checkCount++;
    if (hz.stall_cycles !== 32'd3) begin errorCount++; $display("[TB] FAIL dmem_count got %0d want 3", hz.stall_cycles); end
    @(negedge clk);
    hz.dmem_req_M = 1'b1; hz.dmem_ack = 1'b1;
    #1;
    checkCount++;
    if (ctlVec() !== 7'b0) begin errorCount++; $display("[TB] FAIL dmem_same_ack got %b want %b", ctlVec(), 7'b0); end
    @(negedge clk);
    clearInputs();
    #1;
    checkCount++;
    if (ctlVec() !== 7'b0) begin errorCount++; $display("[TB] FAIL dmem_same_ack_next got %b want %b", ctlVec(), 7'b0); end
    checkCount++;
    if (hz.stall_cycles !== 32'd3) begin errorCount++; $display("[TB] FAIL dmem_same_ack_count got %0d want 3", hz.stall_cycles); end
  endtask

  task automatic test_md_combo();
    logic [6:0] want [0:6];
    want = '{7'b0000000, 7'b1111001, 7'b1111001, 7'b1110000, 7'b1110000, 7'b0000000, 7'b0000110};
    resetDut();
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      clearInputs();
      case (c)
        0: begin hz.md_start_E = 1'b1; hz.dmem_req_M = 1'b1; end
        1: hz.dmem_req_M = 1'b1;
        2: begin hz.dmem_req_M = 1'b1; hz.dmem_ack = 1'b1; end
        4: begin hz.ld_E = 1'b1; hz.rd_E = 5'd4; hz.rs1_D = 5'd4; hz.pcsrc_E = 1'b1; end
        5: hz.md_done = 1'b1;
        6: hz.pcsrc_E = 1'b1;
        default: ;
      endcase
      #1;
      checkCount++;
      if (ctlVec() !== want[c]) begin errorCount++; $display("[TB] FAIL md_combo_c%0d got %b want %b", c, ctlVec(), want[c]); end
    end
    checkCount++;
    if (hz.stall_cycles !== 32'd4) begin errorCount++; $display("[TB] FAIL md_combo_count got %0d want 4", hz.stall_cycles); end
    // mul/div finishing during the memory wait must not leave a stale MD_WAIT
    @(negedge clk);
    clearInputs(); hz.md_start_E = 1'b1; hz.dmem_req_M = 1'b1;
    @(negedge clk);
    clearInputs(); hz.dmem_req_M = 1'b1; hz.md_done = 1'b1;
    #1;
    checkCount++;
    if (ctlVec() !== 7'b1111001) begin errorCount++; $display("[TB] FAIL md_done_in_dmem got %b want %b", ctlVec(), 7'b1111001); end
    @(negedge clk);
    clearInputs(); hz.dmem_req_M = 1'b1; hz.dmem_ack = 1'b1;
    @(negedge clk);
    clearInputs();
    #1;
    checkCount++;
    if (ctlVec() !== 7'b0) begin errorCount++; $display("[TB] FAIL md_pending_cleared got %b want %b", ctlVec(), 7'b0); end
  endtask

  task automatic test_reset_mid_wait();
    resetDut();
    @(negedge clk);
    hz.md_start_E = 1'b1;
    @(negedge clk);
    hz.md_start_E = 1'b0;
    #1;
    checkCount++;
    if (ctlVec() !== 7'b1110000) begin errorCount++; $display("[TB] FAIL rmw_in_md got %b want %b", ctlVec(), 7'b1110000); end
    @(negedge clk);
    #1;
    checkCount++;
    if (hz.stall_cycles !== 32'd1) begin errorCount++; $display("[TB] FAIL rmw_count_before got %0d want 1", hz.stall_cycles); end
    #2;
    rst_n = 1'b0;
    #1;
    checkCount++;
    if (ctlVec() !== 7'b0) begin errorCount++; $display("[TB] FAIL rmw_async_ctl got %b want %b", ctlVec(), 7'b0); end
    checkCount++;
    if (hz.stall_cycles !== 32'd0) begin errorCount++; $display("[TB] FAIL rmw_async_count got %0d want 0", hz.stall_cycles); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkCount++;
    if (ctlVec() !== 7'b0) begin errorCount++; $display("[TB] FAIL rmw_no_replay got %b want %b", ctlVec(), 7'b0); end
    checkCount++;
    if (hz.stall_cycles !== 32'd0) begin errorCount++; $display("[TB] FAIL rmw_count_after got %0d want 0", hz.stall_cycles); end
  endtask

  task automatic test_random();
    resetDut();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      applyStimulus();
      if (!rst_n) modelReset();
      #1;
      modelOutputs();
      checkCount++;
      if (ctlVec() !== eCtl) begin errorCount++; $display("[TB] FAIL rand_ctl %0d got %b want %b", i, ctlVec(), eCtl); end
      checkCount++;
      if ({hz.fwdA_E, hz.fwdB_E} !== {eFwdA, eFwdB}) begin errorCount++; $display("[TB] FAIL rand_fwd %0d got %b want %b", i, {hz.fwdA_E, hz.fwdB_E}, {eFwdA, eFwdB}); end
      checkCount++;
      if (hz.stall_cycles !== mCount) begin errorCount++; $display("[TB] FAIL rand_count %0d got %0d want %0d", i, hz.stall_cycles, mCount); end
      @(posedge clk);
      if (rst_n) modelAdvance();
    end
    @(negedge clk);
    rst_n = 1'b1;
    clearInputs();
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n = 1'b0;
    clearInputs();
    modelReset();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_override();
    test_dmem_wait();
    test_md_combo();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 rs1_D, rs2_D  in  5 each  source registers of the instruction in Decode.
REQ-004 rs1_E, rs2_E, rd_E  in  5 each  source and destination registers in Execute.
REQ-005 rd_M, rd_W  in  5 each  destination registers in Memory and Writeback.
REQ-006 ld_E  in  1  Execute instruction is a load.
REQ-007 regwrite_M, regwrite_W  in  1 each  register-write enables in Memory and Writeback.
REQ-008 pcsrc_E  in  1  taken branch or jump resolved in Execute.
REQ-009 md_start_E  in  1  multi-cycle mul/div issued from Execute.
REQ-010 md_done  in  1  mul/div result valid.
REQ-011 dmem_req_M, dmem_ack  in  1 each  data-memory request in Memory and its completion.
REQ-012 stall_F, stall_D, stall_E, stall_M  out  1 each  hold the PC, IF/ID, ID/EX and EX/MEM registers.
REQ-013 flush_D, flush_E, flush_W  out  1 each  clear IF/ID, ID/EX and MEM/WB to a bubble.
REQ-014 fwdA_E, fwdB_E  out  2 each  operand select: 00 register file, 01 Writeback, 10 Memory.
REQ-015 stall_cycles  out  32  saturating count of cycles with stall_F high.

Function
REQ-016 Forwarding (combinational): fwdA_E SHALL be 10 if regwrite_M, rd_M!=0 and rd_M==rs1_E; else 01 if regwrite_W, rd_W!=0 and rd_W==rs1_E; else 00 (fwdB_E uses rs2_E); Memory wins over Writeback.
REQ-017 FSM states: RUN, DMEM_WAIT, MD_WAIT.
REQ-018 RUN: load-use hazard (ld_E, rd_E!=0, rd_E equals rs1_D or rs2_D) SHALL assert stall_F, stall_D and flush_E for exactly that cycle.
REQ-019 RUN: pcsrc_E SHALL assert flush_D and flush_E in the same cycle; it overrides the load-use stall (stall_F/stall_D low).
REQ-020 RUN -> DMEM_WAIT when dmem_req_M and !dmem_ack; same-cycle ack stays in RUN with no stall.
REQ-021 RUN -> MD_WAIT when md_start_E and not entering DMEM_WAIT; if both occur in one cycle, set md_pending and enter DMEM_WAIT.
REQ-022 DMEM_WAIT: stall_F, stall_D, stall_E, stall_M high and flush_W high; the cycle dmem_ack is seen -> MD_WAIT if md_pending and md_done not yet seen, else RUN.
REQ-023 MD_WAIT: stall_F, stall_D, stall_E high; stall_M low and flush_M is not required (Execute holds, Memory drains); -> RUN the cycle md_done is high; md_done with stalls released in that cycle.
REQ-024 md_done seen while in DMEM_WAIT SHALL clear md_pending.
REQ-025 In DMEM_WAIT or MD_WAIT, load-use and pcsrc_E-driven stall/flush SHALL be suppressed; pcsrc_E is acted on when the FSM returns to RUN and it is still asserted.
REQ-026 Forwarding outputs SHALL remain active in every state.
REQ-027 stall_cycles SHALL increment by 1 each cycle stall_F is high and saturate at 0xFFFF_FFFF.

Reset
REQ-028 While rst_n is low: FSM = RUN, md_pending = 0, stall_cycles = 0, all stall_*/flush_* outputs = 0, regardless of inputs.
REQ-029 Reset asserted mid-wait SHALL abandon the wait immediately; there is no pending replay after release.

Structure
REQ-030 Shared package pipeline_pkg SHALL hold the FSM state enum (RUN, DMEM_WAIT, MD_WAIT) and the forward-select enum (FWD_RF=00, FWD_W=01, FWD_M=10).
REQ-031 Forwarding logic SHALL live in one combinational sub-module, forward_unit, instantiated once per operand.

Verification
REQ-032 rd_M=5, regwrite_M=1, rd_W=5, regwrite_W=1, rs1_E=5 -> fwdA_E=10; rd_M=0 instead -> fwdA_E=01.
REQ-033 ld_E=1, rd_E=7, rs2_D=7 in RUN -> stall_F=stall_D=flush_E=1 for one cycle, stall_cycles=1.
REQ-034 Same load-use plus pcsrc_E=1 -> flush_D=flush_E=1, stall_F=stall_D=0.
REQ-035 dmem_req_M=1 with ack after 3 cycles -> 3 cycles DMEM_WAIT with stall_M=flush_W=1, RUN on ack cycle, stall_cycles=3.
REQ-036 md_start_E and unacked dmem_req_M together, ack at cycle 2, md_done at cycle 5 -> DMEM_WAIT 2 cycles then MD_WAIT until cycle 5, then RUN.
REQ-037 rst_n low during MD_WAIT -> all stall/flush outputs 0 asynchronously, stall_cycles=0, RUN after release.
